// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle around regfile_wb_arbiter: writeback stage, MDU result port,
// hazard-unit query and the shared regfile write port (WE3/WD3/A3).
// The arbiter connects through the slave modport; its environment through master.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  // writeback stage
  logic [2:0]            pipe_we_i;
  logic [DATA_WIDTH-1:0] pipe_wd_i;
  logic [4:0]            pipe_rd_i;
  logic                  pipe_stall_o;
  // MDU result port
  logic                  mdu_valid_i;
  logic [DATA_WIDTH-1:0] mdu_wd_i;
  logic [4:0]            mdu_rd_i;
  logic                  mdu_ready_o;
  // hazard unit
  logic [4:0]            hz_a1_i;
  logic [4:0]            hz_a2_i;
  logic                  hz_o;
  // regfile write port
  logic [2:0]            rf_we_o;
  logic [DATA_WIDTH-1:0] rf_wd_o;
  logic [4:0]            rf_a3_o;

  modport slave (
    input  pipe_we_i, pipe_wd_i, pipe_rd_i, mdu_valid_i, mdu_wd_i, mdu_rd_i,
           hz_a1_i, hz_a2_i,
    output pipe_stall_o, mdu_ready_o, hz_o, rf_we_o, rf_wd_o, rf_a3_o
  );

  modport master (
    output pipe_we_i, pipe_wd_i, pipe_rd_i, mdu_valid_i, mdu_wd_i, mdu_rd_i,
           hz_a1_i, hz_a2_i,
    input  pipe_stall_o, mdu_ready_o, hz_o, rf_we_o, rf_wd_o, rf_a3_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: shares WE3/WD3/A3 between the in-order
// writeback stage and a FIFO of multi-cycle MUL/DIV results. Reports RAW
// hazards on pending results and force-drains a starved FIFO by stalling
// writeback for one cycle.
// Optional feature: define REGFILE_ARB_BYPASS_EN to send an MDU result
// straight to the output register when nothing else competes for the port.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [2:0]       WE_NONE  = 3'b000;
  localparam logic [2:0]       WE_WORD  = 3'b001;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_PIPE,
    GNT_HEAD,
    GNT_BYPASS
  } grant_e;

  // FIFO storage: valid bits are control (reset), rd/wd are payload
  logic                  ent_valid_q [FIFO_DEPTH];
  logic                  ent_valid_d [FIFO_DEPTH];
  logic [4:0]            ent_rd_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] ent_wd_q    [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;

  logic [2:0]            rf_we_q, rf_we_d;
  logic [DATA_WIDTH-1:0] rf_wd_q, rf_wd_d;
  logic [4:0]            rf_a3_q, rf_a3_d;

  grant_e grant;
  logic   pipe_req, fifo_empty, fifo_full, mdu_acc, force_head;
  logic   push, pop, kill_new, hz;

  // Arbitration decision and MDU handshake for the current cycle.
  always_comb begin
    pipe_req   = (bus.pipe_we_i != WE_NONE) && (bus.pipe_rd_i != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    mdu_acc    = bus.mdu_valid_i && !fifo_full;
    force_head = (starve_q == STV_MAX) && !fifo_empty && pipe_req;

    if (force_head)       grant = GNT_HEAD;
    else if (pipe_req)    grant = GNT_PIPE;
    else if (!fifo_empty) grant = GNT_HEAD;
`ifdef REGFILE_ARB_BYPASS_EN
    else if (mdu_acc && (bus.mdu_rd_i != 5'd0)) grant = GNT_BYPASS;
`endif
    else                  grant = GNT_IDLE;

    // x0 results complete the handshake but never occupy a slot
    push     = mdu_acc && (bus.mdu_rd_i != 5'd0) && (grant != GNT_BYPASS);
    pop      = (grant == GNT_HEAD);
    kill_new = (grant == GNT_PIPE) && (bus.mdu_rd_i == bus.pipe_rd_i);
  end

  // FIFO next state: pop clears the head, a granted pipeline write kills
  // older results to the same rd, and the pushed slot is written last so a
  // same-slot pop/push keeps the new entry.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      ent_valid_d[i] = ent_valid_q[i];
      if (pop && (PTR_W'(i) == rd_ptr_q))
        ent_valid_d[i] = 1'b0;
      if ((grant == GNT_PIPE) && (ent_rd_q[i] == bus.pipe_rd_i))
        ent_valid_d[i] = 1'b0;
      if (push && (PTR_W'(i) == wr_ptr_q))
        ent_valid_d[i] = !kill_new;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || pop)       starve_d = '0;
    else if (starve_q != STV_MAX) starve_d = starve_q + STV_W'(1);
    else                          starve_d = starve_q;
  end

  // Output register next state from the grant.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    rf_we_d = WE_NONE;
    rf_wd_d = rf_wd_q;
    rf_a3_d = rf_a3_q;
    case (grant)
      GNT_PIPE: begin
        rf_we_d = bus.pipe_we_i;
        rf_wd_d = bus.pipe_wd_i;
        rf_a3_d = bus.pipe_rd_i;
      end
      GNT_HEAD: begin
        if (ent_valid_q[rd_ptr_q]) begin
          rf_we_d = WE_WORD;
          rf_wd_d = ent_wd_q[rd_ptr_q];
          rf_a3_d = ent_rd_q[rd_ptr_q];
        end
      end
      GNT_BYPASS: begin
        rf_we_d = WE_WORD;
        rf_wd_d = bus.mdu_wd_i;
        rf_a3_d = bus.mdu_rd_i;
      end
      default: ;
    endcase
  end

  // RAW hazard: a source matches a live queued result or the write in flight.
  always_comb begin
    logic m1, m2;
    m1 = (rf_we_q != WE_NONE) && (rf_a3_q == bus.hz_a1_i);
    m2 = (rf_we_q != WE_NONE) && (rf_a3_q == bus.hz_a2_i);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid_q[i] && (ent_rd_q[i] == bus.hz_a1_i)) m1 = 1'b1;
      if (ent_valid_q[i] && (ent_rd_q[i] == bus.hz_a2_i)) m2 = 1'b1;
    end
    hz = ((bus.hz_a1_i != 5'd0) && m1) || ((bus.hz_a2_i != 5'd0) && m2);
  end

  // Control state and output register; reset discards queued results and
  // cancels the write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) ent_valid_q[i] <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rf_we_q  <= WE_NONE;
      rf_wd_q  <= '0;
      rf_a3_q  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) ent_valid_q[i] <= ent_valid_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_wd_q  <= rf_wd_d;
      rf_a3_q  <= rf_a3_d;
    end
  end

  // FIFO payload write on push.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; the valid bits and count gate
    // every use, so stale rd/wd contents are never observed.
    if (push) begin
      ent_rd_q[wr_ptr_q] <= bus.mdu_rd_i;
      ent_wd_q[wr_ptr_q] <= bus.mdu_wd_i;
    end
  end

  assign bus.mdu_ready_o  = !fifo_full;
  assign bus.pipe_stall_o = force_head;
  assign bus.hz_o         = hz;
  assign bus.rf_we_o      = rf_we_q;
  assign bus.rf_wd_o      = rf_wd_q;
  assign bus.rf_a3_o      = rf_a3_q;

endmodule
